// File: rtl/wb_mem_responder.sv
// Pipelined Wishbone responder over a block RAM: clears memory after reset,
// then serves one request per cycle with a fixed ack latency and optional stall injection.
module wb_mem_responder #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int AUX_WIDTH     = 4,
  parameter int LATENCY       = 4,
  parameter int STALL_PERIOD  = 0,
  parameter int OPT_BUS_ABORT = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wb_cyc,
  input  logic                   i_wb_stb,
  input  logic                   i_wb_we,
  input  logic [ADDR_BITS-1:0]   i_wb_addr,
  input  logic [DATA_BITS-1:0]   i_wb_data,
  input  logic [DATA_BITS/8-1:0] i_wb_sel,
  input  logic [AUX_WIDTH-1:0]   i_aux,
  output logic                   o_wb_stall,
  output logic                   o_wb_ack,
  output logic [DATA_BITS-1:0]   o_wb_data,
  output logic [AUX_WIDTH-1:0]   o_aux
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int LANES = DATA_BITS / 8;
  localparam int SP    = (STALL_PERIOD < 2) ? 2 : STALL_PERIOD;
  localparam int SW    = $clog2(SP);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Handshake: a request is taken on a rising edge when cyc (if honoured),
  // stb and !stall are all high; its ack is a single-cycle pulse with data and aux.
  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] clr_cnt_q, clr_cnt_d;
  logic [SW-1:0]        stall_cnt_q, stall_cnt_d;
  logic [LATENCY-1:0]   valid_q, valid_d;
  logic [AUX_WIDTH-1:0] aux_q [LATENCY];
  logic [AUX_WIDTH-1:0] aux_d [LATENCY];
  logic                 we0_q, we0_d;

  logic                 stall;
  logic                 cyc_eff;
  logic                 abort;
  logic                 accept;
  logic                 mem_clr;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [DATA_BITS-1:0] rd_q;
  logic [DATA_BITS-1:0] stage0_data;
  logic [DATA_BITS-1:0] tail_data;

  always_comb begin
    cyc_eff = (OPT_BUS_ABORT != 0) ? i_wb_cyc : 1'b1;
    abort   = (OPT_BUS_ABORT != 0) && !i_wb_cyc;
    stall   = (state_q == CLEAR) ||
              ((STALL_PERIOD != 0) && (stall_cnt_q == SW'(SP - 1)));
    accept  = !i_rst && (state_q == READY) && cyc_eff && i_wb_stb && !stall;
    mem_clr = !i_rst && (state_q == CLEAR);
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d   = clr_cnt_q + 1'b1;
        stall_cnt_d = '0;
        if (&clr_cnt_q) begin
          state_d = READY;
        end
      end
      READY: begin
        stall_cnt_d = (stall_cnt_q == SW'(SP - 1)) ? '0 : stall_cnt_q + 1'b1;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // Stage 0 captures the request; later stages only carry valid and aux,
  // with read data travelling through the tail registers below.
  always_comb begin
    valid_d    = '0;
    valid_d[0] = accept;
    aux_d[0]   = i_aux;
    we0_d      = i_wb_we;
    for (int k = 1; k < LATENCY; k++) begin
      valid_d[k] = valid_q[k-1] && !abort;
      aux_d[k]   = aux_q[k-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      stall_cnt_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      valid_q     <= valid_d;
    end
  end

  always_ff @(posedge i_clk) begin
    we0_q <= we0_d;
    for (int k = 0; k < LATENCY; k++) begin
      aux_q[k] <= aux_d[k];
    end
  end

  // Synchronous-read RAM: a read on the edge after a write sees the new word.
  always_ff @(posedge i_clk) begin
    if (mem_clr) begin
      mem[clr_cnt_q] <= '0;
    end else if (accept && i_wb_we) begin
      for (int b = 0; b < LANES; b++) begin
        if (i_wb_sel[b]) begin
          mem[i_wb_addr][8*b +: 8] <= i_wb_data[8*b +: 8];
        end
      end
    end
    rd_q <= mem[i_wb_addr];
  end

  assign stage0_data = we0_q ? '0 : rd_q;

  generate
    if (LATENCY > 1) begin : g_tail
      logic [DATA_BITS-1:0] data_q [LATENCY-1];
      always_ff @(posedge i_clk) begin
        data_q[0] <= stage0_data;
        for (int k = 1; k < LATENCY - 1; k++) begin
          data_q[k] <= data_q[k-1];
        end
      end
      assign tail_data = data_q[LATENCY-2];
    end else begin : g_head
      assign tail_data = stage0_data;
    end
  endgenerate

  assign o_wb_stall = stall;
  assign o_wb_ack   = valid_q[LATENCY-1];
  assign o_wb_data  = o_wb_ack ? tail_data : '0;
  assign o_aux      = o_wb_ack ? aux_q[LATENCY-1] : '0;

endmodule
